// File: rtl/udgc_pkg.sv
// -----------------------------------------------------------------------------
// udgc_pkg
// Shared types for updown_gray_counter: the MODE and LOAD encodings plus the
// width of the activity counter.
// Optional feature macro used by the top module: UDGC_GRAY_EN.
// -----------------------------------------------------------------------------
package udgc_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD     = 2'b00,
      MODE_UP       = 2'b01,
      MODE_DOWN     = 2'b10,
      MODE_PINGPONG = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      LOAD_NONE = 2'b00,
      LOAD_ZERO = 2'b01,
      LOAD_A    = 2'b10,
      LOAD_B    = 2'b11
   } load_t;

   localparam int ACT_W = 3;

endpackage

// File: rtl/udgc_prescaler.sv
// -----------------------------------------------------------------------------
// udgc_prescaler
// Free-running divider counting 0..DIV-1. TICK is high for the single cycle in
// which the counter holds DIV-1.
// Ports:
//   CLK    in   clock
//   RST_N  in   synchronous active-low reset (counter to 0)
//   TICK   out  one-cycle tick, once every DIV cycles
// -----------------------------------------------------------------------------
module udgc_prescaler #(
   parameter int DIV = 4194304
) (
   input  logic CLK,
   input  logic RST_N,
   output logic TICK
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nx_s;
   logic          last_s;

   // Terminal-count detect and wrap of the divider.
   always_comb begin
      last_s   = (cnt_r == LAST);
      cnt_nx_s = cnt_r;
      if (last_s) begin
         cnt_nx_s = {CW{1'b0}};
      end else begin
         cnt_nx_s = cnt_r + ONE;
      end
   end

   // Divider state register.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_nx_s;
      end
   end

   assign TICK = last_s;

endmodule

// File: rtl/updown_gray_counter.sv
// -----------------------------------------------------------------------------
// updown_gray_counter
// Up / down / ping-pong counter with registered binary and Gray outputs. Steps
// come either from the internal prescaler tick or from the rising edge of the
// (already debounced) manual STEP input; LOAD presets the count and outranks
// any step in the same cycle.
// Optional feature: define UDGC_GRAY_EN to build the Gray register/encoder;
// otherwise GRAY is tied to zero.
// Ports:
//   CLK       in   single clock
//   RST_N     in   synchronous active-low reset
//   STEP_SEL  in   0 = prescaler tick, 1 = rising edge of STEP
//   STEP      in   manual step level
//   MODE      in   00 hold, 01 up, 10 down, 11 ping-pong
//   LOAD      in   00 none, 01 zero, 10 PRESET_A, 11 PRESET_B
//   COUNT     out  binary count
//   GRAY      out  Gray code of COUNT (zero when UDGC_GRAY_EN is undefined)
//   WRAP      out  one-cycle pulse on wrap or ping-pong turnaround
//   DIR       out  1 = counting up, 0 = counting down
//   ACT       out  3-bit activity counter, +1 per prescaler tick
// -----------------------------------------------------------------------------
module updown_gray_counter
   import udgc_pkg::*;
#(
   parameter int          WIDTH    = 10,
   parameter int          DIV      = 4194304,
   parameter int unsigned PRESET_A = 32'd341,   // 10'b0101010101
   parameter int unsigned PRESET_B = 32'd682    // 10'b1010101010
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             STEP_SEL,
   input  logic             STEP,
   input  logic [1:0]       MODE,
   input  logic [1:0]       LOAD,
   output logic [WIDTH-1:0] COUNT,
   output logic [WIDTH-1:0] GRAY,
   output logic             WRAP,
   output logic             DIR,
   output logic [ACT_W-1:0] ACT
);

   localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] MAXV  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] VAL_A = WIDTH'(PRESET_A);
   localparam logic [WIDTH-1:0] VAL_B = WIDTH'(PRESET_B);

   logic             tick_s;
   logic             s1_r;
   logic             s2_r;
   logic             step_ev_s;
   mode_t            mode_s;
   load_t            load_s;

   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] count_nx_s;
   logic             dir_r;
   logic             dir_nx_s;
   logic             wrap_r;
   logic             wrap_nx_s;
   logic [ACT_W-1:0] act_r;

   udgc_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .CLK   (CLK),
      .RST_N (RST_N),
      .TICK  (tick_s)
   );

   // Step source selection; STEP_SEL is applied combinationally so switching
   // it never manufactures an event of its own.
   always_comb begin
      mode_s = mode_t'(MODE);
      load_s = load_t'(LOAD);
      if (STEP_SEL) begin
         step_ev_s = s1_r & ~s2_r;
      end else begin
         step_ev_s = tick_s;
      end
   end

   // Next-state count / direction / wrap: load outranks step, step outranks hold.
   always_comb begin
      count_nx_s = count_r;
      dir_nx_s   = dir_r;
      wrap_nx_s  = 1'b0;
      if (load_s != LOAD_NONE) begin
         case (load_s)
            LOAD_ZERO: count_nx_s = ZERO;
            LOAD_A:    count_nx_s = VAL_A;
            LOAD_B:    count_nx_s = VAL_B;
            default:   count_nx_s = count_r;
         endcase
      end else if (step_ev_s) begin
         case (mode_s)
            MODE_HOLD: begin
               count_nx_s = count_r;
            end
            MODE_UP: begin
               dir_nx_s   = 1'b1;
               count_nx_s = count_r + ONE;
               wrap_nx_s  = (count_r == MAXV);
            end
            MODE_DOWN: begin
               dir_nx_s   = 1'b0;
               count_nx_s = count_r - ONE;
               wrap_nx_s  = (count_r == ZERO);
            end
            MODE_PINGPONG: begin
               // Turnaround reflects off the end value instead of repeating it.
               if (dir_r) begin
                  if (count_r == MAXV) begin
                     count_nx_s = MAXV - ONE;
                     dir_nx_s   = 1'b0;
                     wrap_nx_s  = 1'b1;
                  end else begin
                     count_nx_s = count_r + ONE;
                  end
               end else begin
                  if (count_r == ZERO) begin
                     count_nx_s = ONE;
                     dir_nx_s   = 1'b1;
                     wrap_nx_s  = 1'b1;
                  end else begin
                     count_nx_s = count_r - ONE;
                  end
               end
            end
            default: begin
               count_nx_s = count_r;
            end
         endcase
      end else begin
         count_nx_s = count_r;
      end
   end

   // STEP synchroniser and counter state registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         s1_r    <= 1'b0;
         s2_r    <= 1'b0;
         count_r <= ZERO;
         dir_r   <= 1'b1;
         wrap_r  <= 1'b0;
         act_r   <= {ACT_W{1'b0}};
      end else begin
         s1_r    <= STEP;
         s2_r    <= s1_r;
         count_r <= count_nx_s;
         dir_r   <= dir_nx_s;
         wrap_r  <= wrap_nx_s;
         if (tick_s) begin
            act_r <= act_r + ACT_W'(1);
         end else begin
            act_r <= act_r;
         end
      end
   end

`ifdef UDGC_GRAY_EN
   logic [WIDTH-1:0] gray_r;

   // Gray register fed from the next-state count so it stays aligned with COUNT.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         gray_r <= ZERO;
      end else begin
         gray_r <= count_nx_s ^ (count_nx_s >> 1);
      end
   end

   assign GRAY = gray_r;
`else
   assign GRAY = ZERO;
`endif

   assign COUNT = count_r;
   assign DIR   = dir_r;
   assign WRAP  = wrap_r;
   assign ACT   = act_r;

endmodule
